instr_fetch_unit: RTL and testbench

//  Instruction fetch stage for the RV32 core. Holds the PC and issues one

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response port of the RV32 fetch stage.
// The master side is the fetch unit; the slave side is instruction memory.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch: PC, one outstanding imem request, one-entry output register.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirects in a sticky ERR state.
module instr_fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   imem,
  input  logic                 pc_src_i,
  input  logic [XLEN-1:0]      branch_target_i,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr,
  output logic [XLEN-1:0]      instr_pc,
  input  logic                 decode_ready,
  output logic                 misalign_o
);

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef IFETCH_MISALIGN_CHECK_EN
    , S_ERR
`endif
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_req;
  logic            r_drop;
  logic            r_instr_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;

  logic            w_redirect;
  logic            w_bad_target;
  logic [XLEN-1:0] w_target;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_redirect   = pc_src_i && (r_state != S_ERR);
  assign w_bad_target = |branch_target_i[1:0];
  assign w_target     = branch_target_i;
  assign misalign_o   = r_misalign;
`else
  assign w_redirect   = pc_src_i;
  assign w_bad_target = 1'b0;
  assign w_target     = branch_target_i & ~XLEN'(3);
  assign misalign_o   = 1'b0;
`endif

  assign imem.imem_req_valid = (r_state == S_REQ);
  assign imem.imem_addr      = r_pc;
  assign instr_valid         = r_instr_valid;
  assign instr               = r_instr;
  assign instr_pc            = r_instr_pc;

  // NOTE: all state lives in this one clocked block with non-blocking
  // assignments, so every branch sees the pre-edge values of every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_pc_req      <= RESET_PC;
      r_drop        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= NOP;
      r_instr_pc    <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else if (w_redirect && w_bad_target) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
      // Target is not applied; any in-flight response is ignored from ERR.
      r_state       <= S_ERR;
      r_misalign    <= 1'b1;
      r_instr_valid <= 1'b0;
`endif
    end else if (w_redirect) begin
      r_pc          <= w_target;
      r_instr_valid <= 1'b0;
      if (r_state == S_WAIT) begin
        // A response landing with the redirect retires the stale request now.
        if (imem.imem_rsp_valid) begin
          r_drop  <= 1'b0;
          r_state <= S_REQ;
        end else begin
          r_drop  <= 1'b1;
          r_state <= S_WAIT;
        end
      end else if (r_state == S_REQ && imem.imem_req_ready) begin
        r_pc_req <= r_pc;
        r_drop   <= 1'b1;
        r_state  <= S_WAIT;
      end else begin
        r_state <= S_REQ;
      end
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem.imem_req_ready) begin
            r_pc_req <= r_pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_instr       <= imem.imem_rsp_data;
              r_instr_pc    <= r_pc_req;
              r_instr_valid <= 1'b1;
              r_pc          <= r_pc + XLEN'(4);
              r_state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (decode_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end
        end
`ifdef IFETCH_MISALIGN_CHECK_EN
        S_ERR: r_state <= S_ERR;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; inputs change and outputs are sampled on negedge.
// Exercises the IFETCH_MISALIGN_CHECK_EN path only when that macro is defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src_i;
  logic [31:0] branch_target_i;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;
  logic saw_deadbeef = 1'b0;

  instr_fetch_unit_if imem_if ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem            (imem_if.master),
    .pc_src_i        (pc_src_i),
    .branch_target_i (branch_target_i),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .decode_ready    (decode_ready),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (instr_valid && instr == 32'hDEAD_BEEF) saw_deadbeef = 1'b1;

  task automatic test_reset();
    rst_n = 1'b0; pc_src_i = 1'b0; branch_target_i = '0; decode_ready = 1'b0;
    imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b0; imem_if.imem_rsp_data = '0;
    repeat (3) @(negedge clk);
    total++; if (imem_if.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_if.imem_req_valid); end
    total++; if (imem_if.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_if.imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    @(negedge clk);
    total++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h exp=1/00000000", imem_if.imem_req_valid, imem_if.imem_addr); end
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (imem_if.imem_req_valid !== 1'b0) begin bad++; $display("FAIL wait_req_valid got=%b exp=0", imem_if.imem_req_valid); end
    imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h0050_0093;
    @(negedge clk);
    imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin bad++; $display("FAIL first_instr got=%b/%h/%h exp=1/00500093/00000000", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_hold_stall();
    decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || imem_if.imem_req_valid !== 1'b0) begin bad++; $display("FAIL hold_stall[%0d] got=%b/%h/%b exp=1/00500093/0", i, instr_valid, instr, imem_if.imem_req_valid); end
    end
    decode_ready = 1'b1;
    @(negedge clk);
    decode_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h4) begin bad++; $display("FAIL next_req got=%b/%b/%h exp=0/1/00000004", instr_valid, imem_if.imem_req_valid, imem_if.imem_addr); end
  endtask

  task automatic test_req_stall();
    imem_if.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h4) begin bad++; $display("FAIL req_stall[%0d] got=%b/%h exp=1/00000004", i, imem_if.imem_req_valid, imem_if.imem_addr); end
    end
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0;
    total++; if (imem_if.imem_req_valid !== 1'b0) begin bad++; $display("FAIL req_stall_accept got=%b exp=0", imem_if.imem_req_valid); end
  endtask

  task automatic test_redirect_drop();
    pc_src_i = 1'b1; branch_target_i = 32'h100;
    @(negedge clk);
    pc_src_i = 1'b0;
    total++; if (imem_if.imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL drop_wait got=%b/%b exp=0/0", imem_if.imem_req_valid, instr_valid); end
    imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h100) begin bad++; $display("FAIL drop_reissue got=%b/%b/%h exp=0/1/00000100", instr_valid, imem_if.imem_req_valid, imem_if.imem_addr); end
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h0010_8113;
    @(negedge clk);
    imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h0010_8113 || instr_pc !== 32'h100) begin bad++; $display("FAIL target_instr got=%b/%h/%h exp=1/00108113/00000100", instr_valid, instr, instr_pc); end
    total++; if (saw_deadbeef !== 1'b0) begin bad++; $display("FAIL deadbeef_seen got=%b exp=0", saw_deadbeef); end
  endtask

  task automatic test_flush_hold();
    pc_src_i = 1'b1; branch_target_i = 32'h200; decode_ready = 1'b1;
    @(negedge clk);
    pc_src_i = 1'b0; decode_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h200) begin bad++; $display("FAIL flush_hold got=%b/%b/%h exp=0/1/00000200", instr_valid, imem_if.imem_req_valid, imem_if.imem_addr); end
  endtask

  task automatic test_redirect_on_accept();
    imem_if.imem_req_ready = 1'b1; pc_src_i = 1'b1; branch_target_i = 32'h300;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; pc_src_i = 1'b0;
    total++; if (imem_if.imem_req_valid !== 1'b0) begin bad++; $display("FAIL accept_redirect_wait got=%b exp=0", imem_if.imem_req_valid); end
    imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h300) begin bad++; $display("FAIL accept_redirect_drop got=%b/%b/%h exp=0/1/00000300", instr_valid, imem_if.imem_req_valid, imem_if.imem_addr); end
  endtask

  task automatic test_redirect_with_rsp();
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0;
    pc_src_i = 1'b1; branch_target_i = 32'h400;
    imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h1111_1111;
    @(negedge clk);
    pc_src_i = 1'b0; imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h400) begin bad++; $display("FAIL same_cycle_rsp got=%b/%b/%h exp=0/1/00000400", instr_valid, imem_if.imem_req_valid, imem_if.imem_addr); end
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h2222_2222;
    @(negedge clk);
    imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h2222_2222 || instr_pc !== 32'h400) begin bad++; $display("FAIL no_stale_drop got=%b/%h/%h exp=1/22222222/00000400", instr_valid, instr, instr_pc); end
    decode_ready = 1'b1;
    @(negedge clk);
    decode_ready = 1'b0;
    total++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h404) begin bad++; $display("FAIL post_400_req got=%b/%h exp=1/00000404", imem_if.imem_req_valid, imem_if.imem_addr); end
  endtask

  task automatic test_wrap();
    pc_src_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_src_i = 1'b0;
    total++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_if.imem_req_valid, imem_if.imem_addr); end
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h3333_3333;
    @(negedge clk);
    imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_instr got=%b/%h exp=1/fffffffc", instr_valid, instr_pc); end
    decode_ready = 1'b1;
    @(negedge clk);
    decode_ready = 1'b0;
    total++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_if.imem_req_valid, imem_if.imem_addr); end
  endtask

  task automatic test_misalign();
    pc_src_i = 1'b1; branch_target_i = 32'h102;
    @(negedge clk);
    pc_src_i = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    total++; if (misalign_o !== 1'b1 || imem_if.imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL err_enter got=%b/%b/%b exp=1/0/0", misalign_o, imem_if.imem_req_valid, instr_valid); end
    imem_if.imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (misalign_o !== 1'b1 || imem_if.imem_req_valid !== 1'b0) begin bad++; $display("FAIL err_hold[%0d] got=%b/%b exp=1/0", i, misalign_o, imem_if.imem_req_valid); end
    end
    imem_if.imem_req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", misalign_o); end
    @(negedge clk);
    total++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h0) begin bad++; $display("FAIL err_restart got=%b/%h exp=1/00000000", imem_if.imem_req_valid, imem_if.imem_addr); end
`else
    total++; if (misalign_o !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h100) begin bad++; $display("FAIL force_align got=%b/%b/%h exp=0/1/00000100", misalign_o, imem_if.imem_req_valid, imem_if.imem_addr); end
`endif
  endtask

  task automatic test_reset_mid_request();
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h4444_4444;
    @(negedge clk);
    imem_if.imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_mid got=%b/%b/%h exp=0/1/00000000", instr_valid, imem_if.imem_req_valid, imem_if.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_req_stall();
    test_redirect_drop();
    test_flush_hold();
    test_redirect_on_accept();
    test_redirect_with_rsp();
    test_wrap();
    test_misalign();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
